// File: rtl/poll_pkg.sv
// Shared definitions for the polling booth controller.
//   state_t     : booth session FSM states (encoding visible on o_state)
//   N_CAND_DEF  : default number of candidates
//   VOTES_W     : width of the accepted-vote tally
package poll_pkg;

    localparam int N_CAND_DEF = 4;
    localparam int VOTES_W    = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        COMMIT  = 3'd2,
        RELEASE = 3'd3,
        CLOSED  = 3'd4
    } state_t;

endpackage

// File: rtl/vote_sync.sv
// Two-flop synchronizer for the asynchronous candidate buttons, plus
// classification flags of the synchronized vector.
//   clk, clear : clock and synchronous active-high reset
//   vote       : raw button inputs (asynchronous)
//   vs         : synchronized button vector
//   one_hot    : exactly one button pressed
//   multi      : more than one button pressed
//   none       : no button pressed
module vote_sync #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [N-1:0] vote,
    output logic [N-1:0] vs,
    output logic         one_hot,
    output logic         multi,
    output logic         none
);

    logic [N-1:0] meta_q;
    logic [N-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= vote;
            sync_q <= meta_q;
        end
    end

    assign vs      = sync_q;
    assign none    = (sync_q == '0);
    assign one_hot = $onehot(sync_q);
    assign multi   = !none && !one_hot;

endmodule

// File: rtl/booth_controller.sv
// Voter session sequencer for one polling booth. An officer arms the booth,
// a single synchronized button press is committed as a one-cycle increment
// pulse to that candidate's counter, multi-presses are rejected and retried,
// idle sessions time out and poll close locks the booth until clear.
//   clk, clear   : clock and synchronous active-high reset
//   i_arm        : arm booth for one voter (level)
//   i_close      : poll close request
//   i_tally_clr  : zero the counter bank (honoured in IDLE/CLOSED only)
//   i_vote       : candidate buttons, asynchronous
//   o_inc        : one-cycle increment pulse per candidate counter
//   o_cnt_clear  : one-cycle clear pulse to every counter
//   o_ready      : booth lamp, high while ARMED
//   o_reject     : one-cycle pulse on a multi-button press
//   o_timeout    : one-cycle pulse when an ARMED session expires
//   o_votes_cast : saturating total of accepted votes
//   o_state      : current FSM state (debug)
// Every output is driven straight from a flop.
module booth_controller
    import poll_pkg::*;
#(
    parameter int N_CAND         = N_CAND_DEF,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               i_arm,
    input  logic               i_close,
    input  logic               i_tally_clr,
    input  logic [N_CAND-1:0]  i_vote,
    output logic [N_CAND-1:0]  o_inc,
    output logic               o_cnt_clear,
    output logic               o_ready,
    output logic               o_reject,
    output logic               o_timeout,
    output logic [VOTES_W-1:0] o_votes_cast,
    output logic [2:0]         o_state
);

    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX  = '1;

    logic [N_CAND-1:0] vs;
    logic              vs_one_hot;
    logic              vs_multi;
    logic              vs_none;

    vote_sync #(.N(N_CAND)) u_vote_sync (
        .clk     (clk),
        .clear   (clear),
        .vote    (i_vote),
        .vs      (vs),
        .one_hot (vs_one_hot),
        .multi   (vs_multi),
        .none    (vs_none)
    );

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               pend_q, pend_d;     // close seen during COMMIT/RELEASE
    logic               retry_q, retry_d;   // re-arm after a rejected press
    logic [N_CAND-1:0]  inc_q, inc_d;       // latched one-hot candidate
    logic               cnt_clear_q, cnt_clear_d;
    logic               ready_q, ready_d;
    logic               reject_q, reject_d;
    logic               timeout_q, timeout_d;
    logic [VOTES_W-1:0] votes_q, votes_d;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            retry_q     <= 1'b0;
            inc_q       <= '0;
            cnt_clear_q <= 1'b0;
            ready_q     <= 1'b0;
            reject_q    <= 1'b0;
            timeout_q   <= 1'b0;
            votes_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            retry_q     <= retry_d;
            inc_q       <= inc_d;
            cnt_clear_q <= cnt_clear_d;
            ready_q     <= ready_d;
            reject_q    <= reject_d;
            timeout_q   <= timeout_d;
            // Only written when it actually changes, so the tally holds
            // its value between commits and tally clears.
            if (votes_d != votes_q) begin
                votes_q <= votes_d;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pend_d      = pend_q;
        retry_d     = retry_q;
        inc_d       = '0;
        cnt_clear_d = 1'b0;
        reject_d    = 1'b0;
        timeout_d   = 1'b0;
        votes_d     = votes_q;

        case (state_q)
            IDLE: begin
                if (i_tally_clr) begin
                    cnt_clear_d = 1'b1;
                    votes_d     = '0;
                end
                if (i_close || pend_q) begin
                    state_d = CLOSED;
                    pend_d  = 1'b0;
                end else if (i_arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (i_close || pend_q) begin
                    state_d = CLOSED;
                    pend_d  = 1'b0;
                end else if (vs_one_hot) begin
                    // The increment pulse is issued on entry so that it
                    // coincides with the single COMMIT cycle.
                    state_d = COMMIT;
                    inc_d   = vs;
                    if (votes_q != '1) begin
                        votes_d = votes_q + VOTES_W'(1);
                    end
                end else if (vs_multi) begin
                    state_d  = RELEASE;
                    reject_d = 1'b1;
                    retry_d  = 1'b1;
                end else if (timer_q == T_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else if (timer_q != T_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            COMMIT: begin
                if (i_close) begin
                    pend_d = 1'b1;
                end
                state_d = RELEASE;
            end
            RELEASE: begin
                if (i_close) begin
                    pend_d = 1'b1;
                end
                if (vs_none) begin
                    if (retry_q) begin
                        retry_d = 1'b0;
                        state_d = ARMED;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CLOSED: begin
                if (i_tally_clr) begin
                    cnt_clear_d = 1'b1;
                    votes_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Fresh timer on every ARMED entry; idle value outside ARMED.
        if (state_q != ARMED || state_d != ARMED) begin
            timer_d = '0;
        end

        ready_d = (state_d == ARMED);
    end

    assign o_inc        = inc_q;
    assign o_cnt_clear  = cnt_clear_q;
    assign o_ready      = ready_q;
    assign o_reject     = reject_q;
    assign o_timeout    = timeout_q;
    assign o_votes_cast = votes_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_booth_controller.sv
module tb_booth_controller;

  localparam int N   = 4;
  localparam int TMO = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_COMMIT  = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_CLOSED  = 3'd4;

  logic          clk;
  logic          clear;
  logic          i_arm;
  logic          i_close;
  logic          i_tally_clr;
  logic [N-1:0]  i_vote;
  logic [N-1:0]  o_inc;
  logic          o_cnt_clear;
  logic          o_ready;
  logic          o_reject;
  logic          o_timeout;
  logic [31:0]   o_votes_cast;
  logic [2:0]    o_state;

  booth_controller #(.N_CAND(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .clear        (clear),
    .i_arm        (i_arm),
    .i_close      (i_close),
    .i_tally_clr  (i_tally_clr),
    .i_vote       (i_vote),
    .o_inc        (o_inc),
    .o_cnt_clear  (o_cnt_clear),
    .o_ready      (o_ready),
    .o_reject     (o_reject),
    .o_timeout    (o_timeout),
    .o_votes_cast (o_votes_cast),
    .o_state      (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  int rej_cnt = 0;
  int tmo_cnt = 0;
  int clr_cnt = 0;

  always @(negedge clk) begin
    if (o_reject)    rej_cnt++;
    if (o_timeout)   tmo_cnt++;
    if (o_cnt_clear) clr_cnt++;
    if (o_inc != '0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL inc_unexpected: got %b expected no pulse", o_inc);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        if (o_inc !== e) begin
          n_fail++;
          $display("FAIL inc_value: got %b expected %b", o_inc, e);
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    clear = 1'b1; i_arm = 1'b0; i_close = 1'b0; i_tally_clr = 1'b0; i_vote = '0;
    tick(3);
    clear = 1'b0;
    tick(1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int k;
    k = 0;
    while (o_state !== s && k < budget) begin
      tick(1);
      k++;
    end
    check(name, {29'd0, o_state}, {29'd0, s});
  endtask

  task automatic arm();
    i_arm = 1'b1;
    tick(1);
    i_arm = 1'b0;
    check("armed_ready", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic press(input logic [N-1:0] v, input int hold);
    i_vote = v;
    tick(hold);
    i_vote = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] v1;
    logic [N-1:0] v2;      // retry press after a rejected v1
    logic [N-1:0] exp_inc;
    int           exp_rej;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] exp_votes;

  initial begin
    vecs[0] = '{4'b0001, 4'b0000, 4'b0001, 0};
    vecs[1] = '{4'b0010, 4'b0000, 4'b0010, 0};
    vecs[2] = '{4'b0100, 4'b0000, 4'b0100, 0};
    vecs[3] = '{4'b1000, 4'b0000, 4'b1000, 0};
    vecs[4] = '{4'b0011, 4'b0001, 4'b0001, 1};
    vecs[5] = '{4'b1100, 4'b0100, 4'b0100, 1};
    vecs[6] = '{4'b1111, 4'b1000, 4'b1000, 1};
    vecs[7] = '{4'b0101, 4'b0010, 4'b0010, 1};

    do_reset();

    // reset state
    check("rst_state",  {29'd0, o_state}, 32'd0);
    check("rst_inc",    {28'd0, o_inc}, 32'd0);
    check("rst_ready",  {31'd0, o_ready}, 32'd0);
    check("rst_flags",  {29'd0, o_reject, o_timeout, o_cnt_clear}, 32'd0);
    check("rst_votes",  o_votes_cast, 32'd0);

    // 1) single press with exact latency
    arm();
    i_vote = 4'b0100;
    exp_q.push_back(4'b0100);
    tick(1);
    check("lat_e0", {28'd0, o_inc}, 32'd0);
    tick(1);
    check("lat_e1", {28'd0, o_inc}, 32'd0);
    tick(1);
    check("lat_e2_inc", {28'd0, o_inc}, {28'd0, 4'b0100});
    check("lat_e2_state", {29'd0, o_state}, {29'd0, S_COMMIT});
    check("lat_e2_votes", o_votes_cast, 32'd1);
    tick(1);
    check("lat_e3_inc", {28'd0, o_inc}, 32'd0);
    tick(1);
    i_vote = '0;
    wait_state(S_IDLE, 10, "t1_idle");
    check("t1_ready", {31'd0, o_ready}, 32'd0);
    exp_votes = 32'd1;

    // table-driven sessions
    for (int i = 0; i < 8; i++) begin
      int rej0;
      rej0 = rej_cnt;
      arm();
      exp_q.push_back(vecs[i].exp_inc);
      exp_votes++;
      press(vecs[i].v1, 5);
      if (vecs[i].exp_rej != 0) begin
        wait_state(S_ARMED, 10, "tbl_retry_armed");
        press(vecs[i].v2, 5);
      end
      wait_state(S_IDLE, 10, "tbl_idle");
      check("tbl_reject", rej_cnt - rej0, vecs[i].exp_rej);
      check("tbl_votes", o_votes_cast, exp_votes);
      check("tbl_inc_drain", exp_q.size(), 32'd0);
    end

    // 3) timeout exactly TMO cycles after ARMED entry
    begin
      int early;
      early = 0;
      arm();
      for (int k = 1; k < TMO; k++) begin
        tick(1);
        if (o_timeout || o_state != S_ARMED) early++;
      end
      check("tmo_early", early, 32'd0);
      tick(1);
      check("tmo_pulse", {31'd0, o_timeout}, 32'd1);
      check("tmo_state", {29'd0, o_state}, {29'd0, S_IDLE});
      check("tmo_ready", {31'd0, o_ready}, 32'd0);
      tick(1);
      check("tmo_one_cycle", {31'd0, o_timeout}, 32'd0);
      check("tmo_votes", o_votes_cast, exp_votes);
    end

    // 4) close beats arm; CLOSED ignores arm/vote; tally clear honoured
    i_arm = 1'b1; i_close = 1'b1;
    tick(1);
    i_close = 1'b0;
    check("cls_state", {29'd0, o_state}, {29'd0, S_CLOSED});
    check("cls_ready", {31'd0, o_ready}, 32'd0);
    i_vote = 4'b0001;
    tick(6);
    i_arm = 1'b0; i_vote = '0;
    check("cls_stay", {29'd0, o_state}, {29'd0, S_CLOSED});
    check("cls_votes_kept", o_votes_cast, exp_votes);
    begin
      int c0;
      c0 = clr_cnt;
      i_tally_clr = 1'b1;
      tick(1);
      i_tally_clr = 1'b0;
      check("cls_cnt_clear", {31'd0, o_cnt_clear}, 32'd1);
      check("cls_votes_zero", o_votes_cast, 32'd0);
      tick(1);
      check("cls_clr_pulses", clr_cnt - c0, 32'd1);
    end

    // 5) close during RELEASE is held until IDLE, then taken
    do_reset();
    arm();
    exp_q.push_back(4'b0010);
    i_vote = 4'b0010;
    wait_state(S_RELEASE, 10, "pend_release");
    i_close = 1'b1;
    tick(1);
    i_close = 1'b0;
    i_vote = '0;
    check("pend_not_closed", {29'd0, o_state}, {29'd0, S_RELEASE});
    wait_state(S_IDLE, 10, "pend_idle");
    tick(1);
    check("pend_closed", {29'd0, o_state}, {29'd0, S_CLOSED});
    check("pend_votes", o_votes_cast, 32'd1);

    // 6) clear the cycle before COMMIT suppresses the increment
    do_reset();
    arm();
    i_vote = 4'b1000;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    i_vote = '0;
    check("clr_state", {29'd0, o_state}, {29'd0, S_IDLE});
    check("clr_outs", {23'd0, o_inc, o_cnt_clear, o_ready, o_reject, o_timeout, 1'b0}, 32'd0);
    check("clr_votes", o_votes_cast, 32'd0);
    tick(4);

    // saturated tally: pulse still issued, count pinned
    force dut.votes_q = 32'hFFFF_FFFF;
    #1;
    release dut.votes_q;
    tick(1);
    check("sat_preload", o_votes_cast, 32'hFFFF_FFFF);
    arm();
    exp_q.push_back(4'b0001);
    press(4'b0001, 5);
    wait_state(S_IDLE, 10, "sat_idle");
    check("sat_votes", o_votes_cast, 32'hFFFF_FFFF);

    // held button across sessions is not re-counted
    arm();
    exp_q.push_back(4'b0100);
    i_vote = 4'b0100;
    tick(5);
    i_arm = 1'b1;
    tick(6);
    i_arm = 1'b0;
    check("held_release", {29'd0, o_state}, {29'd0, S_RELEASE});
    i_vote = '0;
    tick(10);
    check("held_end", exp_q.size(), 32'd0);

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
